// File: rtl/axi_lite_cmd_master_if.sv
// AXI4-Lite bus bundle between axi_lite_cmd_master and its slave.
// The master modport drives the address/data/ready channels and the slave modport mirrors it.
interface axi_lite_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axi_lite_cmd_master.sv
// Single-command to AXI4-Lite master bridge: one write or read per command, result on a response port.
// Optional saturating transaction counters are enabled with the AXI_CMD_STATS_EN macro.
module axi_lite_cmd_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    m_axi_aclk,
  input  logic                    m_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  axi_lite_cmd_master_if.master   m_axi
`ifdef AXI_CMD_STATS_EN
  ,
  output logic [15:0]             stat_wr_cnt,
  output logic [15:0]             stat_rd_cnt,
  output logic [15:0]             stat_err_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_WRESP, S_RADDR, S_RDATA, S_RSP
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

  state_e                  state_q, state_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    aw_done_q, aw_done_d;
  logic                    w_done_q, w_done_d;
  logic                    write_q, write_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              resp_q, resp_d;

  logic awvalid, wvalid, arvalid;

  // Valids and readies decode from registered state only, never from a ready input.
  assign awvalid = (state_q == S_WRITE) && !aw_done_q;
  assign wvalid  = (state_q == S_WRITE) && !w_done_q;
  assign arvalid = (state_q == S_RADDR);

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      write_q     <= write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  always_comb begin
    // NOTE: every next-state value defaults to its register first, so no path infers a latch.
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d    = cmd_addr & ALIGN_MASK;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = cmd_write ? S_WRITE : S_RADDR;
        end
      end
      S_WRITE: begin
        if (awvalid && m_axi.awready) aw_done_d = 1'b1;
        if (wvalid && m_axi.wready)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)    state_d   = S_WRESP;
      end
      S_WRESP: begin
        if (m_axi.bvalid) begin
          resp_d  = m_axi.bresp;
          rdata_d = '0;
          state_d = S_RSP;
        end
      end
      S_RADDR: begin
        if (m_axi.arready) state_d = S_RDATA;
      end
      S_RDATA: begin
        if (m_axi.rvalid) begin
          rdata_d = m_axi.rdata;
          resp_d  = m_axi.rresp;
          state_d = S_RSP;
        end
      end
      S_RSP: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = (state_q == S_RSP);
  assign rsp_write = write_q;
  assign rsp_rdata = rdata_q;
  assign rsp_resp  = resp_q;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = wstrb_q;
  assign m_axi.wvalid  = wvalid;
  assign m_axi.bready  = (state_q == S_WRESP);
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid;
  assign m_axi.rready  = (state_q == S_RDATA);

`ifdef AXI_CMD_STATS_EN
  logic [15:0] wr_cnt_q, rd_cnt_q, err_cnt_q;
  logic        rsp_enter;

  // A transaction completes on the cycle the FSM enters RSP.
  assign rsp_enter = (state_q != S_RSP) && (state_d == S_RSP);

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      err_cnt_q <= '0;
    end else if (rsp_enter) begin
      if (write_q && (wr_cnt_q != 16'hFFFF))  wr_cnt_q  <= wr_cnt_q + 16'd1;
      if (!write_q && (rd_cnt_q != 16'hFFFF)) rd_cnt_q  <= rd_cnt_q + 16'd1;
      if ((resp_d != 2'b00) && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign stat_wr_cnt  = wr_cnt_q;
  assign stat_rd_cnt  = rd_cnt_q;
  assign stat_err_cnt = err_cnt_q;
`endif

endmodule

// File: doc/axi_lite_cmd_master.md
Name: axi_lite_cmd_master

Overview:
Simple-command to AXI4-Lite master bridge. It sits directly upstream of the basys3_gpio_v1_0 slave and is used in place of a CPU for bring-up and self-test. One command at a time: a write or a read is accepted on a valid/ready command port, executed as a single AXI-Lite transaction, and the result is returned on a valid/ready response port.

Parameters:
ADDR_WIDTH, 32, width of cmd_addr, m_axi_awaddr and m_axi_araddr.
DATA_WIDTH, 32, data width. Fixed at 32; wstrb is DATA_WIDTH/8 bits.

Ports:
m_axi_aclk  in  1  clock
m_axi_aresetn  in  1  reset, synchronous, active-low
cmd_valid  in  1  command present
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1=write, 0=read
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  32  write data
cmd_wstrb  in  4  write strobes
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_write  out  1  echo of cmd_write
rsp_rdata  out  32  read data (0 for writes)
rsp_resp  out  2  BRESP or RRESP
m_axi_awaddr, m_axi_awprot(3), m_axi_awvalid, m_axi_awready (in), m_axi_wdata, m_axi_wstrb, m_axi_wvalid, m_axi_wready (in), m_axi_bresp (in, 2), m_axi_bvalid (in), m_axi_bready, m_axi_araddr, m_axi_arprot(3), m_axi_arvalid, m_axi_arready (in), m_axi_rdata (in), m_axi_rresp (in, 2), m_axi_rvalid (in), m_axi_rready
- Standard AXI4-Lite master channels.
- All are outputs unless marked (in).

Behaviour:
- Reset (m_axi_aresetn=0 at a clock edge):
  - State goes to IDLE.
  - All m_axi_*valid, m_axi_bready, m_axi_rready, rsp_valid and the address/data/response registers are 0.
  - *prot is constant 3'b000.
  - Reset mid-transaction abandons the transaction. All valids are low the cycle after the reset edge.
- States: IDLE, WRITE, WRESP, RADDR, RDATA, RSP.
- IDLE:
  - cmd_ready=1 (registered; it is 1 only in IDLE, after reset is released).
  - On cmd_valid at edge N: latch addr, with [1:0] forced to 0, plus wdata, wstrb and write.
  - Go to WRITE if write, otherwise RADDR. The AXI valids are high from cycle N+1.
- WRITE:
  - awvalid and wvalid assert together.
  - Each deasserts independently at the edge where its ready is seen. Internal aw_done and w_done flags are set at the same edges.
  - Both handshakes may complete in the same cycle or in either order.
  - When both are done, go to WRESP.
  - Address and data stay stable while their valid is high.
- WRESP: bready=1. On bvalid, capture bresp into rsp_resp, set rsp_rdata=0, go to RSP.
- RADDR: arvalid=1. On arready, deassert and go to RDATA.
- RDATA: rready=1. On rvalid, capture rdata and rresp, go to RSP.
- RSP:
  - rsp_valid=1; rsp_* are stable.
  - On rsp_ready, rsp_valid drops and the state returns to IDLE. cmd_ready=1 on the following cycle.
  - No command is accepted while not in IDLE.
- bready and rready are 0 outside WRESP and RDATA respectively.
- Minimum latency with a zero-wait slave:
  - Write: cmd accept edge N, aw/w handshake N+1, bvalid seen N+2, rsp_valid at N+3.
  - Read: N+1 ar handshake, rvalid N+2, rsp_valid N+3.
- No valid is ever dropped before its handshake. No valid depends combinationally on a ready.

Optional Feature:
Macro AXI_CMD_STATS_EN.
- Defined:
  - Adds outputs stat_wr_cnt[15:0], stat_rd_cnt[15:0] and stat_err_cnt[15:0], all reset to 0.
  - stat_wr_cnt increments on each completed write, stat_rd_cnt on each completed read. Completion is the entry to RSP.
  - stat_err_cnt increments when the captured resp is nonzero.
  - All three saturate at 16'hFFFF.
- Undefined: these ports and the logic do not exist, and behaviour is otherwise identical.

Test Plan:
1. Write, zero-wait slave.
   - Stimulus: cmd write addr 0x04, wdata 0x12AA, wstrb 0xF.
   - Required: awaddr=0x04 and wdata=0x12AA presented together; rsp_valid at N+3; rsp_resp=0; slave LED register reads back 0x12AA.
2. Split write handshake.
   - Stimulus: awready at N+1, wready delayed until N+4, cmd wdata 0xCECE.
   - Required: awvalid low from N+2; wvalid held to N+4; single bready handshake; rsp_resp=0.
3. Read with response backpressure.
   - Stimulus: sw=0xBABA, cmd read addr 0x08, rsp_ready low for 3 cycles.
   - Required: rsp_rdata=0x0000BABA held stable; cmd_ready=0 during the hold; returns to IDLE one cycle after rsp_ready.
4. bvalid delay and error.
   - Stimulus: slave delays bvalid 5 cycles, then bresp=2'b10.
   - Required: bready held high throughout; rsp_resp=2'b10. With AXI_CMD_STATS_EN: stat_err_cnt=1, stat_wr_cnt=1.
5. Busy command and address alignment.
   - Stimulus: cmd_valid with addr 0x0F held high during a read in progress.
   - Required: no second command accepted until after RSP completes; the second transaction goes out with araddr=0x0C.
6. Reset mid-read.
   - Stimulus: m_axi_aresetn low while in RDATA.
   - Required: rready, arvalid and rsp_valid are 0 the cycle after the reset edge; cmd_ready=1 after release.
